io_bridge_fx: RTL and testbench

//  Peripheral-side responder for the fixed-point processor I/O port. Serves processor reads
//  (req_in/addr_in/io_in) from per-address input holding registers filled by external logic.

---
 rtl/io_bridge_fx_if.sv | 45 ++++
 rtl/io_bridge_fx.sv | 141 ++++++++++++++
 tb/tb_io_bridge_fx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/io_bridge_fx_if.sv
// io_bridge_fx_if: bundles the processor I/O port, the external input-fill port
// and the external output-drain port of the fixed-point I/O bridge.
interface io_bridge_fx_if #(
  parameter int NUBITS = 16,
  parameter int NUIOIN = 2,
  parameter int NUIOOU = 2
);
  localparam int IAW = $clog2(NUIOIN);
  localparam int OAW = $clog2(NUIOOU);

  // processor read side
  logic              req_in;
  logic [IAW-1:0]    addr_in;
  logic [NUBITS-1:0] io_in;
  // processor write side
  logic              out_en;
  logic [OAW-1:0]    addr_out;
  logic [NUBITS-1:0] io_out;
  logic              itr;
  // external input fill
  logic              in_wr;
  logic [IAW-1:0]    in_addr;
  logic [NUBITS-1:0] in_data;
  logic [NUIOIN-1:0] in_vld;
  // external output drain
  logic              ou_valid;
  logic              ou_ready;
  logic [OAW-1:0]    ou_addr;
  logic [NUBITS-1:0] ou_data;
  logic [1:0]        ovf;

  // bridge side
  modport slave (
    input  req_in, addr_in, out_en, addr_out, io_out,
    input  in_wr, in_addr, in_data, ou_ready,
    output io_in, itr, in_vld, ou_valid, ou_addr, ou_data, ovf
  );

  // processor / external logic side
  modport master (
    output req_in, addr_in, out_en, addr_out, io_out,
    output in_wr, in_addr, in_data, ou_ready,
    input  io_in, itr, in_vld, ou_valid, ou_addr, ou_data, ovf
  );
endinterface

// File: rtl/io_bridge_fx.sv
// io_bridge_fx: peripheral responder for the fixed-point processor I/O port.
// Reads are served from per-address holding registers; writes are queued in an
// address-tagged first-word-fall-through FIFO; itr pulses on enabled arrivals.
module io_bridge_fx #(
  parameter int                NUBITS = 16,
  parameter int                NUIOIN = 2,
  parameter int                NUIOOU = 2,
  parameter int                FDEPTH = 4,
  parameter logic [NUIOIN-1:0] ITRMSK = '0
) (
  input  logic          clk,
  input  logic          rst,
  io_bridge_fx_if.slave bus
);
  localparam int OAW = $clog2(NUIOOU);
  localparam int AW  = $clog2(FDEPTH);
  localparam int CW  = AW + 1;
  localparam int EW  = OAW + NUBITS;
  localparam logic [CW-1:0] FULL_C  = CW'(FDEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  // ---------------- input side ----------------
  logic [NUBITS-1:0] hold_r [NUIOIN];
  logic [NUIOIN-1:0] vld_r;
  logic              itr_r;
  logic              ovf_in_r;
  logic [NUIOIN-1:0] wr_hit_s;
  logic [NUIOIN-1:0] rd_hit_s;
  logic [NUIOIN-1:0] vld_nxt_s;
  logic [NUIOIN-1:0] arrive_s;
  logic              over_s;
  logic [NUBITS-1:0] rd_data_s;

  // Per-address hit decode; a write on the same address as a read wins.
  always_comb begin
    wr_hit_s  = '0;
    rd_hit_s  = '0;
    vld_nxt_s = vld_r;
    arrive_s  = '0;
    over_s    = 1'b0;
    for (int k = 0; k < NUIOIN; k++) begin
      wr_hit_s[k] = bus.in_wr  && (int'(bus.in_addr) == k);
      rd_hit_s[k] = bus.req_in && (int'(bus.addr_in) == k);
      if (wr_hit_s[k]) begin
        vld_nxt_s[k] = 1'b1;
      end else if (rd_hit_s[k]) begin
        vld_nxt_s[k] = 1'b0;
      end else begin
        vld_nxt_s[k] = vld_r[k];
      end
      // only a fresh arrival (slot was empty) may interrupt
      arrive_s[k] = wr_hit_s[k] && !vld_r[k] && ITRMSK[k];
      // overwrite of unconsumed data is an overflow
      if (wr_hit_s[k] && vld_r[k] && !rd_hit_s[k]) begin
        over_s = 1'b1;
      end else begin
        over_s = over_s;
      end
    end
  end

  // Holding registers, valid flags, interrupt pulse and input overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUIOIN; k++) hold_r[k] <= '0;
      vld_r    <= '0;
      itr_r    <= 1'b0;
      ovf_in_r <= 1'b0;
    end else begin
      for (int k = 0; k < NUIOIN; k++) begin
        if (wr_hit_s[k]) hold_r[k] <= bus.in_data;
      end
      vld_r <= vld_nxt_s;
      itr_r <= |arrive_s;
      if (over_s) ovf_in_r <= 1'b1;
    end
  end

  // Zero-latency read mux; out-of-range addresses read as zero.
  always_comb begin
    rd_data_s = '0;
    if (int'(bus.addr_in) < NUIOIN) begin
      rd_data_s = hold_r[bus.addr_in];
    end else begin
      rd_data_s = '0;
    end
  end

  // ---------------- output FIFO ----------------
  logic [EW-1:0] mem_r [FDEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] cnt_r;
  logic          ovf_ou_r;
  logic          full_s;
  logic          push_s;
  logic          pop_s;
  logic          drop_s;
  logic [EW-1:0] head_s;

  // Handshake decode: a pop frees the slot a simultaneous push needs.
  always_comb begin
    full_s = (cnt_r == FULL_C);
    pop_s  = (cnt_r != '0) && bus.ou_ready;
    push_s = bus.out_en && (!full_s || pop_s);
    drop_s = bus.out_en && full_s && !pop_s;
    head_s = mem_r[rd_ptr_r];
  end

  // FIFO storage, pointers, occupancy and output overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FDEPTH; i++) mem_r[i] <= '0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      cnt_r    <= '0;
      ovf_ou_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {bus.addr_out, bus.io_out};
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_ONE;
        2'b01:   cnt_r <= cnt_r - CNT_ONE;
        default: cnt_r <= cnt_r;
      endcase
      if (drop_s) ovf_ou_r <= 1'b1;
    end
  end

  assign bus.io_in    = rd_data_s;
  assign bus.itr      = itr_r;
  assign bus.in_vld   = vld_r;
  assign bus.ou_valid = (cnt_r != '0);
  assign bus.ou_addr  = head_s[EW-1:NUBITS];
  assign bus.ou_data  = head_s[NUBITS-1:0];
  assign bus.ovf      = {ovf_ou_r, ovf_in_r};
endmodule

// File: tb/tb_io_bridge_fx.sv
// tb_io_bridge_fx: directed vectors with hand-computed expectations for io_bridge_fx.
module tb_io_bridge_fx;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;

  io_bridge_fx_if #(.NUBITS(16), .NUIOIN(2), .NUIOOU(2)) bus ();

  io_bridge_fx #(
    .NUBITS(16), .NUIOIN(2), .NUIOOU(2), .FDEPTH(4), .ITRMSK(2'b01)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_in   = 1'b0;
    bus.addr_in  = 1'b0;
    bus.out_en   = 1'b0;
    bus.addr_out = 1'b0;
    bus.io_out   = 16'h0000;
    bus.in_wr    = 1'b0;
    bus.in_addr  = 1'b0;
    bus.in_data  = 16'h0000;
    bus.ou_ready = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    idle();
    rst = 1'b1;
    #2;
    check_eq("rst_in_vld",   32'(bus.in_vld),   32'h0);
    check_eq("rst_ou_valid", 32'(bus.ou_valid), 32'h0);
    check_eq("rst_ou_data",  32'(bus.ou_data),  32'h0);
    check_eq("rst_ou_addr",  32'(bus.ou_addr),  32'h0);
    check_eq("rst_itr",      32'(bus.itr),      32'h0);
    check_eq("rst_ovf",      32'(bus.ovf),      32'h0);
    check_eq("rst_io_in",    32'(bus.io_in),    32'h0);
    tick();
    rst = 1'b0;
    tick();

    // 1: write addr1, read it back, consume
    bus.in_wr = 1'b1; bus.in_addr = 1'b1; bus.in_data = 16'h1234;
    bus.addr_in = 1'b1;
    tick();
    bus.in_wr = 1'b0;
    check_eq("t1_in_vld",  32'(bus.in_vld), 32'h2);
    check_eq("t1_io_in",   32'(bus.io_in),  32'h1234);
    check_eq("t1_no_itr",  32'(bus.itr),    32'h0);
    bus.req_in = 1'b1;
    tick();
    bus.req_in = 1'b0;
    check_eq("t1_consumed", 32'(bus.in_vld), 32'h0);
    check_eq("t1_data_kept", 32'(bus.io_in), 32'h1234);

    // 2: masked address 0 interrupts once, overwrite sets ovf[0]
    bus.in_wr = 1'b1; bus.in_addr = 1'b0; bus.in_data = 16'h00AA;
    bus.addr_in = 1'b0;
    tick();
    bus.in_wr = 1'b0;
    check_eq("t2_itr_hi",  32'(bus.itr),    32'h1);
    check_eq("t2_in_vld",  32'(bus.in_vld), 32'h1);
    tick();
    check_eq("t2_itr_lo",  32'(bus.itr),    32'h0);
    bus.in_wr = 1'b1; bus.in_data = 16'h00BB;
    tick();
    bus.in_wr = 1'b0;
    check_eq("t2_ovr_no_itr", 32'(bus.itr),   32'h0);
    check_eq("t2_ovf",        32'(bus.ovf),   32'h1);
    check_eq("t2_io_in",      32'(bus.io_in), 32'h00BB);

    // 3: same-cycle write and read on a valid address: write wins, no ovf
    do_reset();
    bus.in_wr = 1'b1; bus.in_addr = 1'b0; bus.in_data = 16'h0011;
    tick();
    bus.in_data = 16'h0055; bus.req_in = 1'b1; bus.addr_in = 1'b0;
    tick();
    bus.in_wr = 1'b0; bus.req_in = 1'b0;
    check_eq("t3_in_vld", 32'(bus.in_vld), 32'h1);
    check_eq("t3_io_in",  32'(bus.io_in),  32'h0055);
    check_eq("t3_ovf",    32'(bus.ovf),    32'h0);
    check_eq("t3_itr",    32'(bus.itr),    32'h0);

    // 4: five writes into a 4-deep FIFO, then drain
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      bus.out_en = 1'b1; bus.addr_out = 1'(i % 2); bus.io_out = 16'(i);
      if (i == 1) check_eq("t4_empty_before", 32'(bus.ou_valid), 32'h0);
      tick();
      if (i == 1) begin
        check_eq("t4_fwft_valid", 32'(bus.ou_valid), 32'h1);
        check_eq("t4_fwft_data",  32'(bus.ou_data),  32'h1);
      end
    end
    bus.out_en = 1'b0;
    check_eq("t4_ovf", 32'(bus.ovf), 32'h2);
    bus.ou_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check_eq("t4_drain_valid", 32'(bus.ou_valid), 32'h1);
      check_eq("t4_drain_data",  32'(bus.ou_data),  32'(i));
      check_eq("t4_drain_addr",  32'(bus.ou_addr),  32'(i % 2));
      tick();
    end
    check_eq("t4_empty_after", 32'(bus.ou_valid), 32'h0);
    tick();
    bus.ou_ready = 1'b0;
    check_eq("t4_ready_when_empty", 32'(bus.ou_valid), 32'h0);

    // 5: full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 10; i <= 13; i++) begin
      bus.out_en = 1'b1; bus.addr_out = 1'b0; bus.io_out = 16'(i);
      tick();
    end
    bus.io_out = 16'd14; bus.addr_out = 1'b1; bus.ou_ready = 1'b1;
    tick();
    bus.out_en = 1'b0;
    check_eq("t5_ovf",  32'(bus.ovf),     32'h0);
    check_eq("t5_head", 32'(bus.ou_data), 32'd11);
    for (int i = 11; i <= 14; i++) begin
      check_eq("t5_drain_valid", 32'(bus.ou_valid), 32'h1);
      check_eq("t5_drain_data",  32'(bus.ou_data),  32'(i));
      tick();
    end
    bus.ou_ready = 1'b0;
    check_eq("t5_empty", 32'(bus.ou_valid), 32'h0);
    check_eq("t5_ovf_end", 32'(bus.ovf), 32'h0);

    // 6: asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.out_en = 1'b1; bus.addr_out = 1'b1; bus.io_out = 16'(16'hA0 + i);
      bus.in_wr = 1'b1; bus.in_addr = 1'(i % 2); bus.in_data = 16'(16'h50 + i);
      tick();
    end
    bus.out_en = 1'b0; bus.in_wr = 1'b0; bus.addr_in = 1'b0;
    check_eq("t6_pre_vld",   32'(bus.in_vld),   32'h3);
    check_eq("t6_pre_valid", 32'(bus.ou_valid), 32'h1);
    check_eq("t6_pre_head",  32'(bus.ou_data),  32'hA0);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_in_vld",   32'(bus.in_vld),   32'h0);
    check_eq("t6_ou_valid", 32'(bus.ou_valid), 32'h0);
    check_eq("t6_ou_addr",  32'(bus.ou_addr),  32'h0);
    check_eq("t6_ou_data",  32'(bus.ou_data),  32'h0);
    check_eq("t6_io_in",    32'(bus.io_in),    32'h0);
    check_eq("t6_itr",      32'(bus.itr),      32'h0);
    check_eq("t6_ovf",      32'(bus.ovf),      32'h0);
    tick();
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
